line_pop_ctrl: RTL and testbench

Read-side controller for a bank of N_LINES line buffers; it is the consumer counterpart to the line-buffer write path. It waits until every buffer holds an unread line, then issues one common pop pulse. It merges the N lock-stepped line streams into one column stream of N pixels per beat. After the line completes it pulses flush to every buffer so they accept the next line.

---
 rtl/line_pop_ctrl_if.sv | 44 ++++
 rtl/line_pop_ctrl.sv | 177 +++++++++++++++++
 tb/tb_line_pop_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_pop_ctrl_if.sv
// Bus bundle between line_pop_ctrl and its line buffers / downstream column sink.
// master = the controller's view, slave = the buffers' and sink's view.
interface line_pop_ctrl_if #(
    parameter int N_LINES  = 3,
    parameter int PX_WIDTH = 30
);
    logic [N_LINES-1:0]          unread_i;
    logic [N_LINES-1:0]          empty_i;
    logic                        pop_line_o;
    logic                        flush_line_o;

    logic [N_LINES*PX_WIDTH-1:0] lines_tdata_i;
    logic [N_LINES-1:0]          lines_tvalid_i;
    logic [N_LINES-1:0]          lines_tlast_i;
    logic [N_LINES-1:0]          lines_tuser_i;
    logic                        lines_tready_o;

    logic [N_LINES*PX_WIDTH-1:0] col_tdata_o;
    logic                        col_tvalid_o;
    logic                        col_tlast_o;
    logic                        col_tuser_o;
    logic                        col_tready_i;

    logic [15:0]                 line_cnt_o;
    logic                        err_o;

    modport master (
        input  unread_i, empty_i,
        input  lines_tdata_i, lines_tvalid_i, lines_tlast_i, lines_tuser_i,
        input  col_tready_i,
        output pop_line_o, flush_line_o, lines_tready_o,
        output col_tdata_o, col_tvalid_o, col_tlast_o, col_tuser_o,
        output line_cnt_o, err_o
    );

    modport slave (
        output unread_i, empty_i,
        output lines_tdata_i, lines_tvalid_i, lines_tlast_i, lines_tuser_i,
        output col_tready_i,
        input  pop_line_o, flush_line_o, lines_tready_o,
        input  col_tdata_o, col_tvalid_o, col_tlast_o, col_tuser_o,
        input  line_cnt_o, err_o
    );
endinterface

// File: rtl/line_pop_ctrl.sv
// Read-side controller for a bank of line buffers: pops one line from every buffer
// together, merges the lock-stepped lanes into one column stream, then flushes.
module line_pop_ctrl #(
    parameter int N_LINES       = 3,
    parameter int PX_WIDTH      = 30,
    parameter int MAX_LINE_SIZE = 1920
) (
    input  logic            clk_i,
    input  logic            rst_i,
    line_pop_ctrl_if.master bus
);
    localparam int BEAT_W = $clog2(MAX_LINE_SIZE + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_LINE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              pop_reg, pop_next;
    logic              flush_reg, flush_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic              sof_line_reg, sof_line_next;
    logic [15:0]       line_cnt_reg, line_cnt_next;
    logic              err_reg, err_next;
    logic              col_valid_reg, col_last_reg, col_user_reg;

    logic start_line;
    logic all_valid;
    logic accept;
    logic lane_end;
    logic overflow;
    logic line_end;
    logic last_mixed;
    logic user_mixed;
    logic line_sof;

    assign start_line = (&bus.unread_i) && !(|bus.empty_i) && !col_valid_reg;
    assign all_valid  = &bus.lines_tvalid_i;
    // The output register may reload in the same cycle it is drained downstream.
    assign accept     = (state_reg == STREAM) && all_valid && (!col_valid_reg || bus.col_tready_i);

    // Lane 0 is authoritative for line end and SOF, even when lanes disagree.
    assign lane_end   = bus.lines_tlast_i[0];
    assign overflow   = !lane_end && (beat_cnt_reg == BEAT_LAST);
    assign line_end   = accept && (lane_end || overflow);
    assign last_mixed = (|bus.lines_tlast_i) && !(&bus.lines_tlast_i);
    assign user_mixed = (|bus.lines_tuser_i) && !(&bus.lines_tuser_i);
    assign line_sof   = (beat_cnt_reg == '0) ? bus.lines_tuser_i[0] : sof_line_reg;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_line) state_next = POP;
            POP:     state_next = STREAM;
            STREAM:  if (line_end) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: pulses are decoded from the upcoming state so they leave a flop.
    always_comb begin
        pop_next   = 1'b0;
        flush_next = 1'b0;
        case (state_next)
            POP:     pop_next   = 1'b1;
            FLUSH:   flush_next = 1'b1;
            default: begin
                pop_next   = 1'b0;
                flush_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pop_reg   <= 1'b0;
            flush_reg <= 1'b0;
        end else begin
            pop_reg   <= pop_next;
            flush_reg <= flush_next;
        end
    end

    // Per-line bookkeeping: beat counter, SOF capture, line counter, sticky error.
    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        sof_line_next = sof_line_reg;
        line_cnt_next = line_cnt_reg;
        err_next      = err_reg;
        if (accept) begin
            if (beat_cnt_reg == '0) begin
                sof_line_next = bus.lines_tuser_i[0];
            end
            if (line_end) begin
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
            end
            if (last_mixed || user_mixed || overflow) begin
                err_next = 1'b1;
            end
        end
        if (line_end) begin
            line_cnt_next = line_sof ? 16'd1 : (line_cnt_reg + 16'd1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_reg <= '0;
            sof_line_reg <= 1'b0;
            line_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            sof_line_reg <= sof_line_next;
            line_cnt_reg <= line_cnt_next;
            err_reg      <= err_next;
        end
    end

    // Column output register control; data lanes are held in the generate below.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_valid_reg <= 1'b0;
            col_last_reg  <= 1'b0;
            col_user_reg  <= 1'b0;
        end else if (accept) begin
            col_valid_reg <= 1'b1;
            col_last_reg  <= lane_end || overflow;
            col_user_reg  <= bus.lines_tuser_i[0];
        end else if (bus.col_tready_i) begin
            col_valid_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LINES; gi++) begin : g_lane
            logic [PX_WIDTH-1:0] data_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_reg <= '0;
                end else if (accept) begin
                    data_reg <= bus.lines_tdata_i[gi*PX_WIDTH +: PX_WIDTH];
                end
            end

            assign bus.col_tdata_o[gi*PX_WIDTH +: PX_WIDTH] = data_reg;
        end
    endgenerate

    assign bus.pop_line_o     = pop_reg;
    assign bus.flush_line_o   = flush_reg;
    assign bus.lines_tready_o = accept;
    assign bus.col_tvalid_o   = col_valid_reg;
    assign bus.col_tlast_o    = col_last_reg;
    assign bus.col_tuser_o    = col_user_reg;
    assign bus.line_cnt_o     = line_cnt_reg;
    assign bus.err_o          = err_reg;
endmodule

// File: tb/tb_line_pop_ctrl.sv
// Directed bench for line_pop_ctrl: three 4-pixel lanes, lane k pixel i = 0x10*k + i.
module tb_line_pop_ctrl;
    localparam int NL  = 3;
    localparam int PXW = 30;
    localparam int DW  = NL * PXW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;

    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    logic          q_user[$];

    line_pop_ctrl_if #(.N_LINES(NL), .PX_WIDTH(PXW)) bus ();

    line_pop_ctrl #(.N_LINES(NL), .PX_WIDTH(PXW), .MAX_LINE_SIZE(1920)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Capture every column handed downstream and count pop pulses.
    always @(negedge clk) begin
        if (!rst && bus.col_tvalid_o && bus.col_tready_i) begin
            q_data.push_back(bus.col_tdata_o);
            q_last.push_back(bus.col_tlast_o);
            q_user.push_back(bus.col_tuser_o);
        end
        if (bus.pop_line_o) n_pop++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PXW-1:0] px(input int k, input int b);
        return PXW'(16 * k + b);
    endfunction

    function automatic logic [DW-1:0] exp_col(input int b);
        return {px(2, b), px(1, b), px(0, b)};
    endfunction

    task automatic wait_pop();
        int n = 0;
        while (bus.pop_line_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pop_seen", bus.pop_line_o, 1'b1);
    endtask

    // Present one line from all buffers; lane 2 may end early, lane 1 may start late.
    task automatic send_line(input int nbeats, input int l2_last, input int l1_delay,
                             input bit sof, input bit toggle, input int stop_at);
        int b = 0;
        int cyc = 0;
        bit held_v = 1'b0;
        logic [DW-1:0] held_d = '0;
        q_data.delete();
        q_last.delete();
        q_user.delete();
        @(posedge clk); #1;
        bus.unread_i = '0;
        while (b < stop_at && cyc < 100) begin
            for (int k = 0; k < NL; k++) begin
                bus.lines_tdata_i[k*PXW +: PXW] = px(k, b);
                bus.lines_tvalid_i[k] = (k != 1) || (cyc >= l1_delay);
                bus.lines_tlast_i[k]  = (k == 2) ? (b == l2_last) : (b == nbeats - 1);
                bus.lines_tuser_i[k]  = sof && (b == 0);
            end
            bus.col_tready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (held_v) chk("stall_hold", bus.col_tdata_o, held_d);
            held_v = bus.col_tvalid_o && !bus.col_tready_i;
            held_d = bus.col_tdata_o;
            if (held_v) chk("stall_tready", bus.lines_tready_o, 1'b0);
            if (!(&bus.lines_tvalid_i)) chk("valid_gate", bus.lines_tready_o, 1'b0);
            if (bus.lines_tready_o) b++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.lines_tvalid_i = '0;
        bus.lines_tlast_i  = '0;
        bus.lines_tuser_i  = '0;
        bus.col_tready_i   = 1'b1;
        chk("beats_sent", b, stop_at);
        if (b == nbeats) begin
            @(negedge clk);
            chk("flush_pulse", bus.flush_line_o, 1'b1);
            @(negedge clk);
            chk("flush_end", bus.flush_line_o, 1'b0);
        end
    endtask

    task automatic check_cols(input int n, input bit sof);
        int g = 0;
        while (q_data.size() < n && g < 30) begin
            @(negedge clk);
            g++;
        end
        chk("col_count", q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            $display("col %0d data=%h last=%b user=%b", i, q_data[i], q_last[i], q_user[i]);
            chk("col_data", q_data[i], exp_col(i));
            chk("col_last", q_last[i], i == n - 1);
            chk("col_user", q_user[i], sof && (i == 0));
        end
    endtask

    initial begin
        bus.unread_i       = '0;
        bus.empty_i        = '0;
        bus.lines_tdata_i  = '0;
        bus.lines_tvalid_i = '0;
        bus.lines_tlast_i  = '0;
        bus.lines_tuser_i  = '0;
        bus.col_tready_i   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", bus.pop_line_o, 1'b0);
        chk("rst_flush", bus.flush_line_o, 1'b0);
        chk("rst_tready", bus.lines_tready_o, 1'b0);
        chk("rst_tvalid", bus.col_tvalid_o, 1'b0);
        chk("rst_tdata", bus.col_tdata_o, '0);
        chk("rst_linecnt", bus.line_cnt_o, 16'd0);
        chk("rst_err", bus.err_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Line 1: SOF line, downstream always ready
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 3, 0, 1'b1, 1'b0, 4);
        check_cols(4, 1'b1);
        chk("l1_linecnt", bus.line_cnt_o, 16'd1);
        chk("l1_err", bus.err_o, 1'b0);
        chk("l1_pops", n_pop, 1);

        // Line 2: downstream ready toggling
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 3, 0, 1'b0, 1'b1, 4);
        check_cols(4, 1'b0);
        chk("l2_linecnt", bus.line_cnt_o, 16'd2);
        chk("l2_pops", n_pop, 2);

        // No pop while any buffer is empty, nor while one buffer lacks a line
        @(posedge clk); #1;
        bus.unread_i = 3'b111;
        bus.empty_i  = 3'b010;
        repeat (5) begin
            @(negedge clk);
            chk("empty_nopop", bus.pop_line_o, 1'b0);
        end
        @(posedge clk); #1;
        bus.empty_i  = 3'b000;
        bus.unread_i = 3'b011;
        repeat (20) begin
            @(negedge clk);
            chk("unread_nopop", bus.pop_line_o, 1'b0);
        end
        @(posedge clk); #1;
        bus.unread_i = 3'b111;
        @(negedge clk);
        chk("pop_not_early", bus.pop_line_o, 1'b0);
        @(negedge clk);
        chk("pop_next_cycle", bus.pop_line_o, 1'b1);
        send_line(4, 3, 0, 1'b0, 1'b0, 4);
        check_cols(4, 1'b0);
        chk("l3_linecnt", bus.line_cnt_o, 16'd3);

        // Line 4: lane 1 valid arrives 5 cycles late
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 3, 5, 1'b0, 1'b0, 4);
        check_cols(4, 1'b0);
        chk("l4_linecnt", bus.line_cnt_o, 16'd4);
        chk("l4_err", bus.err_o, 1'b0);

        // Line 5: lane 2 tlast one beat early -> sticky error, lane 0 ends the line
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 2, 0, 1'b0, 1'b0, 4);
        check_cols(4, 1'b0);
        chk("l5_err", bus.err_o, 1'b1);
        chk("l5_linecnt", bus.line_cnt_o, 16'd5);

        // Line 6: clean line, error stays set
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 3, 0, 1'b0, 1'b0, 4);
        check_cols(4, 1'b0);
        chk("l6_err", bus.err_o, 1'b1);
        chk("l6_linecnt", bus.line_cnt_o, 16'd6);

        // Reset after two beats of a line
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 3, 0, 1'b0, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pop", bus.pop_line_o, 1'b0);
        chk("mid_rst_flush", bus.flush_line_o, 1'b0);
        chk("mid_rst_tready", bus.lines_tready_o, 1'b0);
        chk("mid_rst_tvalid", bus.col_tvalid_o, 1'b0);
        chk("mid_rst_tlast", bus.col_tlast_o, 1'b0);
        chk("mid_rst_tuser", bus.col_tuser_o, 1'b0);
        chk("mid_rst_tdata", bus.col_tdata_o, '0);
        chk("mid_rst_linecnt", bus.line_cnt_o, 16'd0);
        chk("mid_rst_err", bus.err_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Refilled buffers after reset: SOF line restarts the line count
        bus.unread_i = 3'b111;
        wait_pop();
        send_line(4, 3, 0, 1'b1, 1'b0, 4);
        check_cols(4, 1'b1);
        chk("post_rst_linecnt", bus.line_cnt_o, 16'd1);
        chk("post_rst_err", bus.err_o, 1'b0);
        chk("post_rst_pops", n_pop, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
